instr_loader: RTL and testbench
===============================

# instr_loader

Byte-stream instruction loader: the write side of the instruction memory that the fetch/decode/execute datapath only reads. It accepts a framed byte stream (start address, word count, payload) over a valid/ready handshake and assembles big-endian 32-bit MIPS words. Each word is written into instruction memory through a single-cycle write port. While loading it holds the CPU. When loading completes it releases the CPU and presents the start address as the initial PC value.

## Interface
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC)
- ADDR_STEP, 4, address increment per written word (byte-addressed memory)

Ports:
- clk_IL  in  1  clock, rising edge
- rstn_IL  in  1  reset, asynchronous, active-low
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader can accept a byte this cycle
- restart  in  1  single-cycle pulse; starts a new load from DONE or ERR
- mem_wEn  out  1  instruction memory write strobe, one cycle per word
- mem_wAddr  out  ADDR_W  write address
- mem_wData  out  32  write data
- initPC_IL  out  ADDR_W  start address of loaded program (feeds initPCvalue)
- cpuHold  out  1  1 = datapath clock must be gated or held
- load_done  out  1  level; program loaded and accepted
- words_loaded  out  8  count of words written in the current load
- chk_err  out  1  level; checksum mismatch (always 0 unless CHECKSUM_EN)

## Operation
- Transfer: a byte moves on a rising edge with byte_valid && byte_ready. byte_in must hold while byte_valid=1 and byte_ready=0.
- States: IDLE, HDR_ADDR, HDR_CNT, DATA, WRITE, CHECK (macro only), DONE, ERR.
- IDLE -> HDR_ADDR: unconditional on the first edge after reset.
- HDR_ADDR: the accepted byte, with bits[1:0] forced to 00, loads both initPC_IL and the address counter. Next state is HDR_CNT.
- HDR_CNT: the accepted byte is N, the number of words. If N=0, go to CHECK with CHECKSUM_EN defined, otherwise to DONE. If N≠0, go to DATA.
- DATA: shift bytes in MSB first. On the 4th accepted byte, go to WRITE.
- WRITE (one cycle):
  - mem_wEn=1, mem_wAddr=address counter, mem_wData=assembled word.
  - Address counter += ADDR_STEP, modulo 2^ADDR_W (0xFC wraps to 0x00).
  - words_loaded increments.
  - If words_loaded reaches N, go to CHECK or DONE; otherwise return to DATA.
- DONE: cpuHold=0, load_done=1.
- restart:
  - In DONE or ERR, restart clears load_done, chk_err and words_loaded, sets cpuHold=1, and goes to HDR_ADDR.
  - In all other states restart is ignored.
- byte_ready: 1 in HDR_ADDR, HDR_CNT, DATA and CHECK; 0 in all other states.
- Reset mid-load: the state returns to IDLE immediately and all outputs return to their reset values. Partially assembled bytes are discarded. Memory contents already written are not touched.

## Timing
- Reset values:
  - byte_ready=0, mem_wEn=0, mem_wAddr=0, mem_wData=0
  - initPC_IL=0, cpuHold=1, load_done=0, words_loaded=0, chk_err=0
- All outputs are registered or decoded from state. There is no combinational path from byte_valid to byte_ready.
- mem_wEn asserts exactly one cycle after the edge that accepted the 4th byte of a word.
- Minimum of 5 cycles per word: 4 accepts plus 1 WRITE.
- load_done and cpuHold change on the edge entering DONE. The DONE edge follows the final WRITE cycle, or the CHECK accept.
- Simultaneous byte_valid and restart in DONE: restart wins. The byte is not accepted because byte_ready=0.

## Configuration
- CHECKSUM_EN defined:
  - A running XOR is kept over every accepted byte, including both header bytes.
  - After the last word (or directly from HDR_CNT when N=0), CHECK accepts one trailer byte.
  - Trailer equal to the running XOR: go to DONE.
  - Otherwise: go to ERR with chk_err=1, cpuHold=1 and load_done=0.
- CHECKSUM_EN undefined:
  - No trailer byte and no CHECK or ERR states.
  - chk_err is tied to 0.

## Test plan
- Reset, then stream 0x10, 0x02, 0x24,0x08,0x00,0x05, 0x01,0x09,0x50,0x20:
  - Writes 0x24080005 at address 0x10, then 0x01095020 at 0x14.
  - Then load_done=1, cpuHold=0, initPC_IL=0x10, words_loaded=2.
- Header 0xFC, 0x02 followed by two words: the second write lands at 0x00 (wrap). Header 0x13 gives initPC_IL=0x10 (alignment forced).
- byte_valid toggled randomly during DATA: each word is written exactly once with the correct value. byte_ready=0 during every WRITE cycle.
- Assert rstn_IL low in the middle of the 2nd word: outputs immediately take their reset values. A fresh full stream after reset loads correctly.
- Header N=0:
  - Undefined macro: DONE two accepts after reset.
  - Defined macro: trailer 0x10^0x00 gives DONE; a wrong trailer gives ERR, chk_err=1, cpuHold=1.
  - After ERR, a restart pulse returns to HDR_ADDR with chk_err=0.
- restart pulsed during DATA is ignored. A restart pulse in DONE re-raises cpuHold on the next edge and clears load_done and words_loaded.

Source files
------------

// File: rtl/instr_loader.sv
// Framed byte-stream loader: header (start addr, word count) + big-endian payload,
// written one 32-bit word per cycle into instruction memory. Define CHECKSUM_EN for an XOR trailer check.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk_IL,
  input  logic              rstn_IL,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              restart,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_wAddr,
  output logic [31:0]       mem_wData,
  output logic [ADDR_W-1:0] initPC_IL,
  output logic              cpuHold,
  output logic              load_done,
  output logic [7:0]        words_loaded,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] initpc_q, initpc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        words_q, words_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        bcnt_q, bcnt_d;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic       accept;
  logic [7:0] aligned;
  logic [7:0] words_inc;

  assign accept    = byte_valid & byte_ready;
  assign aligned   = {byte_in[7:2], 2'b00};
  assign words_inc = words_q + 8'd1;

  // State register
  always_ff @(posedge clk_IL or negedge rstn_IL) begin
    if (!rstn_IL) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_HDR_ADDR;
      S_HDR_ADDR: if (accept) state_d = S_HDR_CNT;
      S_HDR_CNT:  if (accept) state_d = (byte_in == 8'd0) ? S_END : S_DATA;
      S_DATA:     if (accept && bcnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:    state_d = (words_inc == cnt_q) ? S_END : S_DATA;
`ifdef CHECKSUM_EN
      S_CHECK:    if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
      S_ERR:      if (restart) state_d = S_HDR_ADDR;
`endif
      S_DONE:     if (restart) state_d = S_HDR_ADDR;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; byte_ready never depends on byte_valid
  always_comb begin
    byte_ready = (state_q == S_HDR_ADDR) || (state_q == S_HDR_CNT) ||
                 (state_q == S_DATA)     || (state_q == S_CHECK);
    mem_wEn    = (state_q == S_WRITE);
    load_done  = (state_q == S_DONE);
    cpuHold    = (state_q != S_DONE);
`ifdef CHECKSUM_EN
    chk_err    = (state_q == S_ERR);
`else
    chk_err    = 1'b0;
`endif
  end

  assign mem_wAddr    = addr_q;
  assign mem_wData    = shift_q;
  assign initPC_IL    = initpc_q;
  assign words_loaded = words_q;

  always_comb begin
    addr_d   = addr_q;
    initpc_d = initpc_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_HDR_ADDR: if (accept) begin
        addr_d   = ADDR_W'(aligned);
        initpc_d = ADDR_W'(aligned);
      end
      S_HDR_CNT:  if (accept) cnt_d = byte_in;
      S_DATA:     if (accept) begin
        shift_d = {shift_q[23:0], byte_in};
        bcnt_d  = bcnt_q + 2'd1;
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
        words_d = words_inc;
      end
      S_DONE, S_ERR: if (restart) begin
        words_d = '0;
        bcnt_d  = '0;
`ifdef CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      default: ;
    endcase
`ifdef CHECKSUM_EN
    // Running XOR covers both header bytes and all payload, not the trailer
    if (accept && state_q != S_CHECK) csum_d = csum_q ^ byte_in;
`endif
  end

  always_ff @(posedge clk_IL or negedge rstn_IL) begin
    if (!rstn_IL) begin
      addr_q   <= '0;
      initpc_q <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      shift_q  <= '0;
      bcnt_q   <= '0;
`ifdef CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      addr_q   <= addr_d;
      initpc_q <= initpc_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
`ifdef CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random framed streams against a queue-based model of expected writes.
module tb_instr_loader;
  logic        clk_IL = 1'b0;
  logic        rstn_IL = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        restart = 1'b0;
  logic        byte_ready, mem_wEn, cpuHold, load_done, chk_err;
  logic [7:0]  mem_wAddr, initPC_IL, words_loaded;
  logic [31:0] mem_wData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] wq[$];

  instr_loader dut (
    .clk_IL(clk_IL), .rstn_IL(rstn_IL), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .restart(restart), .mem_wEn(mem_wEn), .mem_wAddr(mem_wAddr),
    .mem_wData(mem_wData), .initPC_IL(initPC_IL), .cpuHold(cpuHold), .load_done(load_done),
    .words_loaded(words_loaded), .chk_err(chk_err)
  );

  always #5 clk_IL = ~clk_IL;

  // Memory-side observer: record every write, and ready must be low while writing
  always @(negedge clk_IL) begin
    if (rstn_IL && mem_wEn === 1'b1) begin
      got_a.push_back(mem_wAddr);
      got_d.push_back(mem_wData);
      n_checks++;
      if (byte_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_in_write: got %0b expected 0", byte_ready);
      end
    end
  end

  task automatic do_reset();
    rstn_IL = 1'b0; byte_valid = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk_IL);
    rstn_IL = 1'b1;
    @(negedge clk_IL);
    got_a.delete(); got_d.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int t;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) @(negedge clk_IL);
    byte_in = b; byte_valid = 1'b1; t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin @(negedge clk_IL); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++; $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(negedge clk_IL);
    byte_valid = 1'b0; byte_in = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (load_done !== 1'b1 && t < 10) begin @(negedge clk_IL); t++; end
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL %s_done_timeout: got %0b expected 1", tag, load_done); end
  endtask

  // Streams header + wq payload (+ trailer) and checks the resulting writes and status
  task automatic run_load(input logic [7:0] a, input int maxgap, input string tag);
    int n;
    logic [7:0] x, b;
    logic [31:0] w;
    int ea;
    n = wq.size();
    got_a.delete(); got_d.delete();
    x = a ^ n[7:0];
    send_byte(a, maxgap);
    send_byte(n[7:0], maxgap);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      ea = ((int'(a) & 'hFC) + 4 * i) % 256;
      for (int k = 0; k < 4; k++) begin
        b = 8'(w >> (24 - 8 * k));
        x = x ^ b;
        send_byte(b, maxgap);
      end
      n_checks++;
      if (mem_wEn !== 1'b1 || mem_wAddr !== ea[7:0]) begin
        n_fail++; $display("FAIL %s_write_timing: wEn=%0b addr=%0h expected wEn=1 addr=%0h", tag, mem_wEn, mem_wAddr, ea[7:0]);
      end
    end
`ifdef CHECKSUM_EN
    send_byte(x, maxgap);
`endif
    wait_done(tag);
    n_checks++;
    if ({load_done, cpuHold, chk_err} !== 3'b100) begin
      n_fail++; $display("FAIL %s_status: done/hold/err=%b expected 100", tag, {load_done, cpuHold, chk_err});
    end
    n_checks++;
    if (initPC_IL !== (a & 8'hFC)) begin
      n_fail++; $display("FAIL %s_initpc: got %0h expected %0h", tag, initPC_IL, a & 8'hFC);
    end
    n_checks++;
    if (words_loaded !== n[7:0]) begin
      n_fail++; $display("FAIL %s_words: got %0d expected %0d", tag, words_loaded, n);
    end
    n_checks++;
    if (got_a.size() != n) begin
      n_fail++; $display("FAIL %s_write_count: got %0d expected %0d", tag, got_a.size(), n);
    end
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      ea = ((int'(a) & 'hFC) + 4 * i) % 256;
      n_checks++;
      if (got_a[i] !== ea[7:0] || got_d[i] !== wq[i]) begin
        n_fail++; $display("FAIL %s_write%0d: got %0h@%0h expected %0h@%0h", tag, i, got_d[i], got_a[i], wq[i], ea[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    rstn_IL = 1'b0;
    repeat (2) @(negedge clk_IL);
    n_checks++;
    if ({byte_ready, mem_wEn, mem_wAddr, mem_wData} !== 42'h0) begin
      n_fail++; $display("FAIL reset_mem: got %0h expected 0", {byte_ready, mem_wEn, mem_wAddr, mem_wData});
    end
    n_checks++;
    if ({initPC_IL, cpuHold, load_done, words_loaded, chk_err} !== {8'h0, 1'b1, 1'b0, 8'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_status: pc=%0h hold=%0b done=%0b words=%0d err=%0b expected 0 1 0 0 0",
                         initPC_IL, cpuHold, load_done, words_loaded, chk_err);
    end
    rstn_IL = 1'b1;
    @(negedge clk_IL);
  endtask

  task automatic test_basic();
    do_reset();
    wq = '{32'h24080005, 32'h01095020};
    run_load(8'h10, 0, "basic");
  endtask

  task automatic test_wrap_align();
    do_reset();
    wq = '{32'hA5A5_0001, 32'h5A5A_0002};
    run_load(8'hFC, 0, "wrap");
    do_reset();
    wq = '{32'hCAFE_F00D};
    run_load(8'h13, 1, "align");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = int'($urandom_range(6, 1));
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_load(8'($urandom), 3, "random");
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h40, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    send_byte(8'h55, 1); send_byte(8'h66, 1);
    rstn_IL = 1'b0;
    #1;
    n_checks++;
    if ({byte_ready, mem_wEn, mem_wAddr, mem_wData, initPC_IL, cpuHold, load_done, words_loaded, chk_err}
        !== {1'b0, 1'b0, 8'h0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_outputs: hold=%0b done=%0b words=%0d pc=%0h data=%0h expected reset values",
                         cpuHold, load_done, words_loaded, initPC_IL, mem_wData);
    end
    n_checks++;
    if (got_a.size() != 1) begin
      n_fail++; $display("FAIL midreset_writes: got %0d expected 1", got_a.size());
    end
    @(negedge clk_IL);
    rstn_IL = 1'b1;
    @(negedge clk_IL);
    wq = '{32'h0BAD_BEEF, 32'h1234_5678, 32'h8765_4321};
    run_load(8'h44, 2, "after_reset");
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h10, 0); send_byte(8'h00, 0);
`ifndef CHECKSUM_EN
    n_checks++;
    if ({load_done, cpuHold, words_loaded, initPC_IL} !== {1'b1, 1'b0, 8'h00, 8'h10}) begin
      n_fail++; $display("FAIL zero_done: done=%0b hold=%0b words=%0d pc=%0h expected 1 0 0 10",
                         load_done, cpuHold, words_loaded, initPC_IL);
    end
`else
    n_checks++;
    if ({load_done, byte_ready} !== 2'b01) begin
      n_fail++; $display("FAIL zero_check_state: done/ready=%b expected 01", {load_done, byte_ready});
    end
    send_byte(8'h10 ^ 8'h00, 0);
    n_checks++;
    if ({load_done, cpuHold, chk_err} !== 3'b100) begin
      n_fail++; $display("FAIL zero_good_trailer: done/hold/err=%b expected 100", {load_done, cpuHold, chk_err});
    end
    restart = 1'b1; @(negedge clk_IL); restart = 1'b0;
    send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h55, 0);
    n_checks++;
    if ({load_done, cpuHold, chk_err} !== 3'b011) begin
      n_fail++; $display("FAIL zero_bad_trailer: done/hold/err=%b expected 011", {load_done, cpuHold, chk_err});
    end
    restart = 1'b1; @(negedge clk_IL); restart = 1'b0;
    n_checks++;
    if ({chk_err, byte_ready, cpuHold} !== 3'b011) begin
      n_fail++; $display("FAIL err_restart: err/ready/hold=%b expected 011", {chk_err, byte_ready, cpuHold});
    end
`endif
  endtask

  task automatic test_restart();
    logic [7:0] s[10];
    logic [7:0] x;
    do_reset();
    s = '{8'h20, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    x = 8'h00;
    for (int i = 0; i < 10; i++) begin
      x = x ^ s[i];
      send_byte(s[i], 0);
      if (i == 4) begin restart = 1'b1; @(negedge clk_IL); restart = 1'b0; end
    end
`ifdef CHECKSUM_EN
    send_byte(x, 0);
`endif
    wait_done("restart_ignored");
    n_checks++;
    if (got_a.size() != 2 || got_d[0] !== 32'hDEADBEEF || got_a[0] !== 8'h20 ||
        got_d[1] !== 32'h12345678 || got_a[1] !== 8'h24) begin
      n_fail++; $display("FAIL restart_ignored_writes: got %0d writes, first %0h expected 2 writes DEADBEEF@20 12345678@24",
                         got_a.size(), (got_d.size() > 0) ? got_d[0] : 32'h0);
    end
    // restart and a byte offered together in DONE: restart wins, byte not taken
    restart = 1'b1; byte_valid = 1'b1; byte_in = 8'h40;
    @(negedge clk_IL);
    restart = 1'b0; byte_valid = 1'b0;
    n_checks++;
    if ({cpuHold, load_done, words_loaded, byte_ready} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL done_restart: hold=%0b done=%0b words=%0d ready=%0b expected 1 0 0 1",
                         cpuHold, load_done, words_loaded, byte_ready);
    end
    wq = '{32'h0000_0C0D};
    run_load(8'h30, 0, "reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_align();
    test_random();
    test_mid_reset();
    test_zero_count();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
